// File: rtl/mat_xfer_ctrl_pkg.sv
// Shared sizes, select/mode codes and FSM encoding for the matrix register-bank transfer controller.
package mat_xfer_pkg;
  localparam int WORD_W = 16;
  localparam int MAT_W  = 200;
  localparam int NWORDS = (MAT_W + WORD_W - 1) / WORD_W;

  localparam logic [3:0] LAST_IDX = 4'd12;

  localparam logic [1:0] SEL_B = 2'd0;
  localparam logic [1:0] SEL_A = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  typedef enum logic [1:0] {
    MODE_LOAD_B  = 2'b00,
    MODE_LOAD_A  = 2'b01,
    MODE_READ_C  = 2'b10,
    MODE_LOAD_AB = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_e;

  function automatic logic [1:0] first_sel(input mode_e m);
    case (m)
      MODE_LOAD_B: return SEL_B;
      MODE_READ_C: return SEL_C;
      default:     return SEL_A;
    endcase
  endfunction
endpackage

// File: rtl/mat_xfer_ctrl_if.sv
// Register-bank strobe bus: the controller drives address/data/strobe, the bank returns read data.
interface mat_xfer_ctrl_if;
  import mat_xfer_pkg::*;

  logic [WORD_W-1:0] bus_wdata;
  logic [5:0]        bus_adrs;
  logic              bus_done;
  logic [WORD_W-1:0] bus_rdata;

  modport master (output bus_wdata, output bus_adrs, output bus_done, input bus_rdata);
  modport slave  (input bus_wdata, input bus_adrs, input bus_done, output bus_rdata);
endinterface

// File: rtl/mat_xfer_ctrl_word_mux.sv
// Picks one 16-bit word out of a 200-bit matrix; the top word carries 8 data bits plus zero padding.
module mat_word_mux
  import mat_xfer_pkg::*;
(
  input  logic [MAT_W-1:0]  mat,
  input  logic [3:0]        idx,
  output logic [WORD_W-1:0] word
);
  localparam int PAD_W = WORD_W * NWORDS - MAT_W;

  logic [WORD_W-1:0] words [16];

  always_comb begin
    for (int k = 0; k < 16; k++) words[k] = '0;
    for (int k = 0; k < NWORDS - 1; k++) words[k] = mat[k*WORD_W +: WORD_W];
    words[NWORDS-1] = {{PAD_W{1'b0}}, mat[MAT_W-1:(NWORDS-1)*WORD_W]};
  end

  assign word = words[idx];
endmodule

// File: rtl/mat_xfer_ctrl.sv
// Matrix transfer initiator: serialises A/B into bank writes and gathers C from bank reads.
// Optional strobe counter on xfer_count is enabled with MAT_XFER_COUNT_EN.
module mat_xfer_ctrl
  import mat_xfer_pkg::*;
#(
  parameter int STROBE_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [MAT_W-1:0] src_a,
  input  logic [MAT_W-1:0] src_b,
  mat_xfer_ctrl_if.master  bus,
  output logic [MAT_W-1:0] result_c,
  output logic             busy,
  output logic             xfer_done,
  output logic             cmd_err,
  output logic [15:0]      xfer_count
);
  localparam logic [1:0] STB_LAST = 2'(STROBE_W - 1);

  state_e            state;
  mode_e             mode_q;
  logic [1:0]        sel, n_sel;
  logic [3:0]        idx, n_idx;
  logic              more;
  logic [1:0]        stb_cnt;
  logic [MAT_W-1:0]  a_q, b_q, mux_mat;
  logic [WORD_W-1:0] mux_word;
  logic [WORD_W-1:0] shadow [NWORDS-1];
  logic [WORD_W*(NWORDS-1)-1:0] shadow_flat;

  // Next word to put on the bus: first word of a new command, or the successor after HOLD.
  always_comb begin
    n_sel = sel;
    n_idx = idx + 4'd1;
    more  = 1'b1;
    if (state == ST_IDLE) begin
      n_sel = first_sel(mode_e'(mode));
      n_idx = '0;
    end else if (idx == LAST_IDX) begin
      if (mode_q == MODE_LOAD_AB && sel == SEL_A) begin
        n_sel = SEL_B;
        n_idx = '0;
      end else begin
        more = 1'b0;
      end
    end
  end

  // Sources are not yet captured in IDLE, so the first word comes straight from the ports.
  assign mux_mat = (state == ST_IDLE) ? ((n_sel == SEL_B) ? src_b : src_a)
                                      : ((n_sel == SEL_B) ? b_q   : a_q);

  mat_word_mux u_word_mux (
    .mat  (mux_mat),
    .idx  (n_idx),
    .word (mux_word)
  );

  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < NWORDS - 1; k++) shadow_flat[k*WORD_W +: WORD_W] = shadow[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mode_q        <= MODE_LOAD_B;
      sel           <= SEL_B;
      idx           <= '0;
      stb_cnt       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      result_c      <= '0;
      busy          <= 1'b0;
      xfer_done     <= 1'b0;
      cmd_err       <= 1'b0;
      bus.bus_wdata <= '0;
      bus.bus_adrs  <= '0;
      bus.bus_done  <= 1'b0;
      for (int k = 0; k < NWORDS - 1; k++) shadow[k] <= '0;
    end else begin
      xfer_done <= 1'b0;
      cmd_err   <= start && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q       <= mode_e'(mode);
            a_q          <= src_a;
            b_q          <= src_b;
            sel          <= n_sel;
            idx          <= n_idx;
            busy         <= 1'b1;
            bus.bus_adrs <= {n_sel, n_idx};
            if (n_sel != SEL_C) bus.bus_wdata <= mux_word;
            state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          bus.bus_done <= 1'b1;
          stb_cnt      <= '0;
          state        <= ST_STROBE;
        end
        ST_STROBE: begin
          if (stb_cnt == STB_LAST) begin
            bus.bus_done <= 1'b0;
            state        <= ST_HOLD;
          end else begin
            stb_cnt <= stb_cnt + 2'd1;
          end
        end
        ST_HOLD: begin
          if (sel == SEL_C && idx != LAST_IDX) shadow[idx] <= bus.bus_rdata;
          if (more) begin
            sel          <= n_sel;
            idx          <= n_idx;
            bus.bus_adrs <= {n_sel, n_idx};
            if (n_sel != SEL_C) bus.bus_wdata <= mux_word;
            state        <= ST_SETUP;
          end else begin
            // The last read word merges straight in so result_c is whole during DONE.
            if (sel == SEL_C)
              result_c <= {bus.bus_rdata[MAT_W-(NWORDS-1)*WORD_W-1:0], shadow_flat};
            xfer_done <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MAT_XFER_COUNT_EN
  // Every SETUP is followed by a strobe, so leaving SETUP marks one bus_done rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xfer_count <= '0;
    else if (state == ST_SETUP && xfer_count != 16'hFFFF)
      xfer_count <= xfer_count + 16'd1;
  end
`else
  assign xfer_count = '0;
`endif
endmodule

// File: tb/tb_mat_xfer_ctrl.sv
// Randomised bench for mat_xfer_ctrl with a cycle-schedule reference model and directed literal checks.
module tb_mat_xfer_ctrl;
  localparam int SW = 1;
  localparam int P  = SW + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [199:0] src_a, src_b;
  logic [199:0] result_c;
  logic         busy, xfer_done, cmd_err;
  logic [15:0]  xfer_count;
  logic [15:0]  c_mem [16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mat_xfer_ctrl_if bus_if ();

  mat_xfer_ctrl #(.STROBE_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .src_a      (src_a),
    .src_b      (src_b),
    .bus        (bus_if.master),
    .result_c   (result_c),
    .busy       (busy),
    .xfer_done  (xfer_done),
    .cmd_err    (cmd_err),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank read port: returns the C word addressed by the low address bits.
  always_comb bus_if.bus_rdata = c_mem[bus_if.bus_adrs[3:0]];

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [199:0] s, input int j);
    if (j < 12) return 16'(s >> (16 * j));
    return {8'h00, s[199:192]};
  endfunction

  function automatic logic [5:0] adrs_of(input logic [1:0] md, input int j);
    case (md)
      2'b00:   return {2'b00, 4'(j % 13)};
      2'b01:   return {2'b01, 4'(j % 13)};
      2'b10:   return {2'b10, 4'(j % 13)};
      default: return (j < 13) ? {2'b01, 4'(j)} : {2'b00, 4'(j - 13)};
    endcase
  endfunction

  function automatic logic [15:0] wd_of(input logic [1:0] md, input logic [199:0] a,
                                        input logic [199:0] b, input int j);
    if (md == 2'b00) return word_of(b, j % 13);
    if (md == 2'b11 && j >= 13) return word_of(b, j - 13);
    return word_of(a, j % 13);
  endfunction

  function automatic logic [199:0] res_of();
    logic [199:0] r = '0;
    for (int k = 0; k < 12; k++) r = r | ({184'b0, c_mem[k]} << (16 * k));
    r[199:192] = c_mem[12][7:0];
    return r;
  endfunction

  function automatic logic [199:0] rand200();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
    return t[199:0];
  endfunction

  // Reference model: a command is a schedule of words, P cycles each, then one DONE cycle.
  logic         m_active, m_read, m_cerr;
  int           m_c, m_n;
  logic [5:0]   m_hold_a;
  logic [15:0]  m_hold_w;
  logic [199:0] m_result, m_newres;
  logic [15:0]  m_count;
  logic [5:0]   e_adrs [26];
  logic [15:0]  e_wd   [26];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_read   <= 1'b0;
      m_cerr   <= 1'b0;
      m_c      <= 0;
      m_n      <= 1;
      m_hold_a <= '0;
      m_hold_w <= '0;
      m_result <= '0;
      m_newres <= '0;
      m_count  <= '0;
    end else begin
      m_cerr <= start && m_active;
      if (m_active) begin
        if (m_c == m_n * P) begin
          m_active <= 1'b0;
          m_hold_a <= e_adrs[m_n-1];
          m_hold_w <= e_wd[m_n-1];
          if (m_read) m_result <= m_newres;
        end else begin
`ifdef MAT_XFER_COUNT_EN
          if (m_c % P == 0 && m_count != 16'hFFFF) m_count <= m_count + 16'd1;
`endif
          m_c <= m_c + 1;
        end
      end else if (start) begin
        m_active <= 1'b1;
        m_c      <= 0;
        m_n      <= (mode == 2'b11) ? 26 : 13;
        m_read   <= (mode == 2'b10);
        m_newres <= res_of();
        for (int j = 0; j < 26; j++) begin
          e_adrs[j] <= adrs_of(mode, j);
          e_wd[j]   <= (mode == 2'b10) ? m_hold_w : wd_of(mode, src_a, src_b, j);
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic         e_done, e_busy, e_xd;
    logic [5:0]   e_a;
    logic [15:0]  e_w;
    logic [199:0] e_res;
    if (rst_n) begin
      e_done = 1'b0; e_busy = 1'b0; e_xd = 1'b0;
      e_a = m_hold_a; e_w = m_hold_w; e_res = m_result;
      if (m_active) begin
        e_busy = 1'b1;
        if (m_c < m_n * P) begin
          e_done = (m_c % P >= 1) && (m_c % P <= SW);
          e_a    = e_adrs[m_c / P];
          e_w    = e_wd[m_c / P];
        end else begin
          e_xd = 1'b1;
          e_a  = e_adrs[m_n-1];
          e_w  = e_wd[m_n-1];
          if (m_read) e_res = m_newres;
        end
      end
      check("bus_done",   bus_if.bus_done,  e_done);
      check("busy",       busy,             e_busy);
      check("xfer_done",  xfer_done,        e_xd);
      check("cmd_err",    cmd_err,          m_cerr);
      check("bus_adrs",   bus_if.bus_adrs,  e_a);
      check("bus_wdata",  bus_if.bus_wdata, e_w);
      check("result_c",   result_c,         e_res);
      check("xfer_count", xfer_count,       m_count);
    end
  end

  // inj: 0 quiet, 1 start at cycle 5 and on DONE, 2 random start noise while busy.
  task automatic run_xfer(input logic [1:0] md, input int inj, output int lat, output int strobes,
                          output logic [5:0] first_a, output logic [5:0] last_a,
                          output logic [15:0] last_w, output int errs);
    int   t0;
    int   post = -1;
    logic prev = 1'b0;
    lat = -1; strobes = 0; errs = 0;
    first_a = '0; last_a = '0; last_w = '0;
    @(negedge clk);
    mode  = md;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    for (int i = 0; i < 400 && post < 3; i++) begin
      @(negedge clk);
      if (bus_if.bus_done && !prev) begin
        strobes++;
        if (strobes == 1) first_a = bus_if.bus_adrs;
        last_a = bus_if.bus_adrs;
        last_w = bus_if.bus_wdata;
      end
      prev = bus_if.bus_done;
      if (cmd_err) errs++;
      start = 1'b0;
      if (post >= 0) post++;
      else if (xfer_done) begin
        lat  = cyc - t0 + 1;
        post = 0;
        if (inj != 0) start = 1'b1;
      end
      else if (inj == 1 && cyc - t0 == 5) start = 1'b1;
      else if (inj == 2) start = ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    check("xfer_finished", post >= 0, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, strobes, errs, n_rise, hit;
    logic [5:0]  fa, la;
    logic [15:0] lw;
    logic        prev;

    rst_n = 1'b0; start = 1'b0; mode = 2'b00;
    src_a = '0; src_b = '0;
    for (int k = 0; k < 16; k++) c_mem[k] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",       busy,             1'b0);
    check("rst_bus_done",   bus_if.bus_done,  1'b0);
    check("rst_adrs",       bus_if.bus_adrs,  6'h00);
    check("rst_wdata",      bus_if.bus_wdata, 16'h0000);
    check("rst_result",     result_c,         200'h0);
    check("rst_xfer_count", xfer_count,       16'h0000);
    @(negedge clk); #2 rst_n = 1'b1;

    // Load A with word k = 0x0100 + k
    for (int k = 0; k < 12; k++) src_a[k*16 +: 16] = 16'h0100 + 16'(k);
    src_a[199:192] = 8'h0C;
    src_b = rand200();
    run_xfer(2'b01, 0, lat, strobes, fa, la, lw, errs);
    check("a_latency",    lat,     40);
    check("a_strobes",    strobes, 13);
    check("a_first_adrs", fa,      6'h10);
    check("a_last_adrs",  la,      6'h1C);
    check("a_last_wdata", lw,      16'h000C);

    // Load A then B
    src_a = rand200();
    src_b = rand200();
    run_xfer(2'b11, 0, lat, strobes, fa, la, lw, errs);
    check("ab_latency",    lat,     79);
    check("ab_strobes",    strobes, 26);
    check("ab_first_adrs", fa,      6'h10);
    check("ab_last_adrs",  la,      6'h0C);
    check("ab_last_wdata", lw,      {8'h00, src_b[199:192]});

    // Read C from a bank holding 0xC000 + k
    for (int k = 0; k < 13; k++) c_mem[k] = 16'hC000 + 16'(k);
    run_xfer(2'b10, 0, lat, strobes, fa, la, lw, errs);
    check("c_latency",  lat,               40);
    check("c_word0",    result_c[15:0],    16'hC000);
    check("c_word11",   result_c[191:176], 16'hC00B);
    check("c_top_bits", result_c[199:192], 8'h0C);

    // Start while busy and on the DONE cycle
    src_a = rand200();
    run_xfer(2'b01, 1, lat, strobes, fa, la, lw, errs);
    check("err_pulses",  errs,    2);
    check("err_strobes", strobes, 13);
    check("err_latency", lat,     40);
    check("err_idle",    busy,    1'b0);

    // Reset during the strobe of word 6
    @(negedge clk);
    mode  = 2'b01;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_rise = 0; hit = 0; prev = 1'b0;
    for (int i = 0; i < 100 && hit == 0; i++) begin
      @(negedge clk);
      if (bus_if.bus_done && !prev) n_rise++;
      prev = bus_if.bus_done;
      if (n_rise == 7 && bus_if.bus_done) hit = 1;
    end
    check("rst_reach_word6", hit, 1);
    check("rst_word6_adrs",  bus_if.bus_adrs, 6'h16);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bus_done",  bus_if.bus_done, 1'b0);
    check("arst_busy",      busy,            1'b0);
    check("arst_xfer_done", xfer_done,       1'b0);
    @(negedge clk); #2 rst_n = 1'b1;
    run_xfer(2'b01, 0, lat, strobes, fa, la, lw, errs);
    check("post_rst_first_adrs", fa,  6'h10);
    check("post_rst_latency",    lat, 40);

    // Random commands, data and start noise
    for (int t = 0; t < 12; t++) begin
      src_a = rand200();
      src_b = rand200();
      for (int k = 0; k < 13; k++) c_mem[k] = 16'($urandom());
      run_xfer(2'($urandom_range(0, 3)), 2, lat, strobes, fa, la, lw, errs);
    end

    // Strobe counter over two A-then-B commands from reset
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    run_xfer(2'b11, 0, lat, strobes, fa, la, lw, errs);
    run_xfer(2'b11, 0, lat, strobes, fa, la, lw, errs);
`ifdef MAT_XFER_COUNT_EN
    check("count_two_ab", xfer_count, 16'd52);
`else
    check("count_two_ab", xfer_count, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mat_xfer_ctrl.md
Name: mat_xfer_ctrl

Overview:
Initiator side of the matrix register-bank write/read strobe protocol. It serializes the 200-bit operand matrices A and B into 16-bit words and issues one address+strobe write per word to the coprocessor register bank. On a read command it strobes out the 13 words of result matrix C and reassembles them into a 200-bit register. It sits between the host command interface and the coprocessor register bank.

Parameters:
WORD_W, 16, bus word width.
MAT_W, 200, matrix vector width.
NWORDS, 13, words per matrix, ceil(MAT_W/WORD_W); derived, not overridden.
STROBE_W, 1, cycles bus_done is held high per word (range 1..4).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  command request, sampled only in IDLE
mode  in  2  00 load B, 01 load A, 10 read C, 11 load A then B
src_a  in  200  matrix A source, captured at accepted start
src_b  in  200  matrix B source, captured at accepted start
bus_wdata  out  16  word to bank data input
bus_adrs  out  6  [5:4] select (0=B, 1=A, 2=C), [3:0] word index 0..12
bus_done  out  1  write/read strobe; bank acts on its rising edge
bus_rdata  in  16  word from bank data output
result_c  out  200  reassembled matrix C
busy  out  1  transfer in progress
xfer_done  out  1  one-cycle completion pulse
cmd_err  out  1  one-cycle pulse: start while busy, or start with mode ignored
xfer_count  out  16  see Optional Feature

Behaviour:
- Reset, async on rst_n low: all outputs 0, FSM IDLE, internal captures 0. Reset mid-transfer abandons the transfer. No xfer_done pulse. bus_done drops immediately.
- States: IDLE, SETUP, STROBE, HOLD, NEXT, DONE.
- IDLE: start=1 latches mode, src_a, src_b; word index is 0; go to SETUP. busy goes high on the following cycle.
- SETUP, 1 cycle: drive bus_adrs and bus_wdata for the current word; bus_done=0.
- STROBE, STROBE_W cycles: bus_done=1; address and data are held.
- HOLD, 1 cycle: bus_done=0; address and data are held. For a read, bus_rdata is sampled at the clock edge that leaves HOLD.
- NEXT is combinational in the HOLD exit decision, not a cycle:
  - if index < 12: index+1, then SETUP;
  - else if mode=11 and the current select is A: select becomes B, index 0, then SETUP;
  - else DONE.
- Word k payload: bits [16k+15:16k] for k = 0..11. Word 12 = {8'h00, bits[199:192]}; the padding is always zero.
- Read: word k is stored into a shadow register. For word 12, only bits [7:0] are used. result_c is updated atomically from the shadow in DONE, and is otherwise stable.
- DONE, 1 cycle: xfer_done=1, busy still 1. Next state is IDLE, where busy=0.
- Latency with STROBE_W=1: 3 cycles per word. A start accepted at edge t0 gives xfer_done at t0+40 for a single matrix and t0+79 for mode 11.
- start while busy: ignored, and cmd_err pulses.
- start in the same cycle as DONE: ignored, with cmd_err. start is accepted only in IDLE.
- bus_wdata and bus_adrs keep their last values in IDLE; they are not zeroed.

Optional Feature:
Macro MAT_XFER_COUNT_EN.
- Defined: xfer_count increments by 1 on every bus_done rising edge issued. It saturates at 16'hFFFF and clears only on reset.
- Undefined: xfer_count is tied to 0 and no counter logic is present. The port exists in both builds.

Decomposition:
- Package mat_xfer_pkg holds:
  - select codes SEL_B=2'd0, SEL_A=2'd1, SEL_C=2'd2;
  - mode codes;
  - NWORDS and LAST_IDX=4'd12;
  - the state enum.
- Sub-module mat_word_mux (combinational): given a 200-bit matrix and a 4-bit index, returns the 16-bit word with the word-12 zero padding. It is instanced once on the selected source.

Test Plan:
- Reset, then mode=01 with src_a = word k = 16'h0100+k -> 13 strobes, bus_adrs 6'h10..6'h1C, last bus_wdata 16'h00xx holding bits [199:192], xfer_done at t0+40.
- mode=11 with distinct A and B -> 26 strobes, A words then B words with addresses 6'h00..6'h0C; bus_done never high in SETUP/HOLD; xfer_done at t0+79.
- mode=10 with a bank model returning 16'hC000+k -> result_c words = C000+k; bits [199:192] = 8'h0C; result_c unchanged until the DONE cycle.
- start pulsed at cycle 5 of a transfer and again on the DONE cycle -> two cmd_err pulses, transfer unaffected, no new transfer begun.
- rst_n low during the STROBE of word 6 -> bus_done=0 asynchronously, busy=0, no xfer_done; a new start then runs from index 0.
- With MAT_XFER_COUNT_EN, two mode-11 transfers -> xfer_count=52; without the macro, xfer_count=0.
